// File: rtl/tpu_sequencer_if.sv
// rtl/tpu_sequencer_if.sv - datapath control bundle between the sequencer and the TPU loaders/MMU/store path
interface tpu_sequencer_if #(
    parameter int ADDR_W = 13
);
    logic              op_ready;
    logic [ADDR_W-1:0] base_address;
    logic              load_weight;
    logic              load_input;
    logic              valid;
    logic              store;

    // The sequencer drives strobes and the base address; the datapath answers with op_ready
    modport master (
        input  op_ready,
        output base_address,
        output load_weight,
        output load_input,
        output valid,
        output store
    );

    modport slave (
        output op_ready,
        input  base_address,
        input  load_weight,
        input  load_input,
        input  valid,
        input  store
    );
endinterface

// File: rtl/tpu_sequencer.sv
// rtl/tpu_sequencer.sv - programmable instruction sequencer driving the TPU datapath strobes
module tpu_sequencer #(
    parameter int OPCODE_W       = 3,
    parameter int ADDR_W         = 13,
    parameter int IMEM_DEPTH     = 16,
    parameter int PC_W           = 4,
    parameter int COMPUTE_CYCLES = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       imem_we,
    input  logic [PC_W-1:0]            imem_waddr,
    input  logic [OPCODE_W+ADDR_W-1:0] imem_wdata,
    tpu_sequencer_if.master            dp,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [PC_W-1:0]            pc
);
    localparam int IW = OPCODE_W + ADDR_W;

    localparam logic [OPCODE_W-1:0] OP_HALT        = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LOAD_ADDR   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LOAD_WEIGHT = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_LOAD_INPUT  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_COMPUTE     = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_STORE       = OPCODE_W'(5);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [IW-1:0]       imem [IMEM_DEPTH];
    logic [IW-1:0]       ir;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   base_q;

    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   imm;
    logic [ADDR_W-1:0]   compute_len;
    logic                last_pc;

    logic                start_acc;
    logic                retire;
    logic                cnt_inc;
    logic                load_base;
    logic                set_error;
    logic                lw;
    logic                li;
    logic                vld;
    logic                st;

    assign opcode      = ir[IW-1 -: OPCODE_W];
    assign imm         = ir[ADDR_W-1:0];
    // A zero immediate selects the default COMPUTE length
    assign compute_len = (imm != '0) ? imm : ADDR_W'(COMPUTE_CYCLES);
    // Reaching the last word ends the program instead of wrapping back to 0
    assign last_pc     = (pc == PC_W'(IMEM_DEPTH - 1));

    assign dp.base_address = base_q;
    assign dp.load_weight  = lw;
    assign dp.load_input   = li;
    assign dp.valid        = vld;
    assign dp.store        = st;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, strobes and datapath control for the current instruction
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        lw         = 1'b0;
        li         = 1'b0;
        vld        = 1'b0;
        st         = 1'b0;
        start_acc  = 1'b0;
        retire     = 1'b0;
        cnt_inc    = 1'b0;
        load_base  = 1'b0;
        set_error  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                case (opcode)
                    OP_HALT: begin
                        state_next = S_DONE;
                    end
                    OP_LOAD_ADDR: begin
                        load_base = 1'b1;
                        retire    = 1'b1;
                    end
                    OP_LOAD_WEIGHT: begin
                        lw     = 1'b1;
                        retire = dp.op_ready;
                    end
                    OP_LOAD_INPUT: begin
                        li     = 1'b1;
                        retire = dp.op_ready;
                    end
                    OP_COMPUTE: begin
                        vld = 1'b1;
                        if (cnt == compute_len - ADDR_W'(1)) begin
                            retire = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                    OP_STORE: begin
                        st     = 1'b1;
                        retire = dp.op_ready;
                    end
                    default: begin
                        set_error  = 1'b1;
                        state_next = S_DONE;
                    end
                endcase
                if (retire) begin
                    state_next = last_pc ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Program counter, instruction register, COMPUTE counter, base address and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            ir     <= '0;
            cnt    <= '0;
            base_q <= '0;
            error  <= 1'b0;
        end else begin
            if (start_acc) begin
                pc    <= '0;
                error <= 1'b0;
            end
            if (state == S_FETCH) begin
                ir  <= imem[pc];
                cnt <= '0;
            end
            if (cnt_inc) begin
                cnt <= cnt + ADDR_W'(1);
            end
            if (load_base) begin
                base_q <= imm;
            end
            if (set_error) begin
                error <= 1'b1;
            end
            if (retire && !last_pc) begin
                pc <= pc + PC_W'(1);
            end
        end
    end

    // Instruction memory write port; kept out of reset so programs survive it
    always_ff @(posedge clk) begin
        if (imem_we && !busy) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end
endmodule

// File: tb/tb_tpu_sequencer.sv
// tb/tb_tpu_sequencer.sv - scoreboard testbench for tpu_sequencer
module tb_tpu_sequencer;
    localparam int EV_LW   = 1;
    localparam int EV_LI   = 2;
    localparam int EV_V    = 3;
    localparam int EV_ST   = 4;
    localparam int EV_DONE = 5;

    typedef struct {
        int          kind;
        logic [12:0] addr;
        logic        err;
        logic [3:0]  pc;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  pc;

    int          checks;
    int          errors;
    ev_t         exp_q[$];
    logic [15:0] tb_mem [16];
    logic [12:0] m_base;

    logic [31:0] w_lw, w_li, w_v, w_st, w_done, w_busy;
    logic [12:0] w_base [32];

    int          mon_kind;
    int          mon_nstb;
    ev_t         mon_e;

    tpu_sequencer_if #(.ADDR_W(13)) bus ();

    tpu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .dp         (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int imm);
        return {op[2:0], imm[12:0]};
    endfunction

    function automatic void push_ev(input int kind, input logic [12:0] a, input logic err, input int p);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.err  = err;
        e.pc   = p[3:0];
        exp_q.push_back(e);
    endfunction

    // Reference interpreter: walks the program and lists every strobe/valid/done it must produce
    task automatic push_model();
        int          n;
        logic [2:0]  op;
        logic [12:0] imm;
        for (int p = 0; p < 16; p++) begin
            op  = tb_mem[p][15:13];
            imm = tb_mem[p][12:0];
            if (op == 3'd0) begin
                push_ev(EV_DONE, 13'd0, 1'b0, p);
                return;
            end
            if (op > 3'd5) begin
                push_ev(EV_DONE, 13'd0, 1'b1, p);
                return;
            end
            case (op)
                3'd1: m_base = imm;
                3'd2: push_ev(EV_LW, m_base, 1'b0, p);
                3'd3: push_ev(EV_LI, m_base, 1'b0, p);
                3'd4: begin
                    n = (imm == 13'd0) ? 6 : int'(imm);
                    for (int k = 0; k < n; k++) push_ev(EV_V, m_base, 1'b0, p);
                end
                default: push_ev(EV_ST, m_base, 1'b0, p);
            endcase
            if (p == 15) push_ev(EV_DONE, 13'd0, 1'b0, 15);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an accepted strobe, a valid beat or done
    always @(negedge clk) begin
        if (!reset) begin
            mon_nstb = int'(bus.load_weight) + int'(bus.load_input) + int'(bus.valid) + int'(bus.store);
            check("strobe_exclusive", {31'd0, (mon_nstb <= 1) && (busy || mon_nstb == 0)}, 32'd1);
            mon_kind = 0;
            if (bus.load_weight && bus.op_ready) mon_kind = EV_LW;
            if (bus.load_input && bus.op_ready)  mon_kind = EV_LI;
            if (bus.valid)                       mon_kind = EV_V;
            if (bus.store && bus.op_ready)       mon_kind = EV_ST;
            if (done)                            mon_kind = EV_DONE;
            if (mon_kind != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", mon_kind, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", mon_kind, mon_e.kind);
                    if (mon_kind == EV_DONE) begin
                        check("done_error", {31'd0, error}, {31'd0, mon_e.err});
                        check("done_pc", {28'd0, pc}, {28'd0, mon_e.pc});
                    end else begin
                        check("event_base", {19'd0, bus.base_address}, {19'd0, mon_e.addr});
                    end
                end
            end
        end
    end

    task automatic write_imem(input int a, input logic [15:0] w);
        imem_we    = 1'b1;
        imem_waddr = a[3:0];
        imem_wdata = w;
        @(posedge clk); #1;
        imem_we    = 1'b0;
        tb_mem[a]  = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Cycle-exact window: cycle 0 carries start; op_ready rises at ready_from
    task automatic run_window(input int n, input int ready_from, input int restart_at);
        push_model();
        w_lw = '0; w_li = '0; w_v = '0; w_st = '0; w_done = '0; w_busy = '0;
        for (int i = 0; i < n; i++) begin
            start        = (i == 0) || (i == restart_at);
            bus.op_ready = (i >= ready_from);
            @(negedge clk);
            w_lw[i]   = bus.load_weight;
            w_li[i]   = bus.load_input;
            w_v[i]    = bus.valid;
            w_st[i]   = bus.store;
            w_done[i] = done;
            w_busy[i] = busy;
            w_base[i] = bus.base_address;
            @(posedge clk); #1;
        end
        start        = 1'b0;
        bus.op_ready = 1'b0;
    endtask

    // Run the stored program to done, with optional same-cycle write, busy poke or mid-run reset
    task automatic run_program(input bit rnd_ready, input bit we0_en, input logic [15:0] we0_word,
                               input int poke_at, input int reset_at);
        bit         seen;
        logic [3:0] pc_poke;
        seen    = 1'b0;
        pc_poke = '0;
        if (we0_en) tb_mem[0] = we0_word;
        push_model();
        for (int i = 0; i < 2000; i++) begin
            start        = (i == 0) || (i == poke_at);
            imem_we      = (i == 0 && we0_en) || (i == poke_at);
            imem_waddr   = 4'd0;
            imem_wdata   = (i == 0) ? we0_word : mk(1, 13'h1AB);
            reset        = (i == reset_at);
            bus.op_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (i == 1) begin
                check("busy_in_fetch", {31'd0, busy}, 32'd1);
                check("error_clear_on_start", {31'd0, error}, 32'd0);
            end
            if (i == poke_at) pc_poke = pc;
            if (poke_at >= 0 && i == poke_at + 1) check("pc_held_when_busy", {28'd0, pc}, {28'd0, pc_poke});
            if (reset_at >= 0 && i == reset_at + 1) begin
                check("reset_valid", {31'd0, bus.valid}, 32'd0);
                check("reset_busy", {31'd0, busy}, 32'd0);
                check("reset_base", {19'd0, bus.base_address}, 32'd0);
                check("reset_done", {31'd0, done}, 32'd0);
                check("reset_pc", {28'd0, pc}, 32'd0);
                seen = 1'b1;
            end
            if (done) seen = 1'b1;
            @(posedge clk); #1;
            if (i == reset_at) begin
                reset = 1'b0;
                exp_q.delete();
                m_base = '0;
            end
            if (seen) break;
        end
        start        = 1'b0;
        imem_we      = 1'b0;
        reset        = 1'b0;
        bus.op_ready = 1'b0;
        check("program_finished", {31'd0, seen}, 32'd1);
        idle(3);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        bus.op_ready = 1'b0; m_base = '0;
        for (int i = 0; i < 16; i++) tb_mem[i] = '0;
        idle(3);
        @(negedge clk);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_base", {19'd0, bus.base_address}, 32'd0);
        check("rst_flags", {28'd0, busy, done, error, 1'b0}, 32'd0);
        check("rst_strobes", {28'd0, bus.load_weight, bus.load_input, bus.valid, bus.store}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);

        // Reference program with cycle-exact strobe placement
        write_imem(0, mk(1, 13'h00F)); write_imem(1, mk(2, 0));
        write_imem(2, mk(1, 13'h01E)); write_imem(3, mk(3, 0));
        write_imem(4, mk(4, 0));       write_imem(5, mk(1, 13'h007));
        write_imem(6, mk(5, 0));       write_imem(7, mk(0, 0));
        run_window(26, 0, -1);
        check("t1_lw", w_lw, 32'h0000_0010);
        check("t1_li", w_li, 32'h0000_0100);
        check("t1_valid", w_v, 32'h0000_FC00);
        check("t1_store", w_st, 32'h0008_0000);
        check("t1_done", w_done, 32'h0040_0000);
        check("t1_base_lw", {19'd0, w_base[4]}, 32'h00F);
        check("t1_base_li", {19'd0, w_base[8]}, 32'h01E);
        check("t1_base_st", {19'd0, w_base[19]}, 32'h007);
        idle(2);

        // COMPUTE with explicit immediates
        write_imem(0, mk(4, 3)); write_imem(1, mk(0, 0));
        run_window(9, 0, -1);
        check("t2_valid3", w_v, 32'h0000_001C);
        check("t2_done3", w_done, 32'h0000_0080);
        idle(2);
        write_imem(0, mk(4, 1));
        run_window(9, 0, -1);
        check("t2_valid1", w_v, 32'h0000_0004);
        check("t2_done1", w_done, 32'h0000_0020);
        idle(2);

        // STORE stalled by op_ready, plus a start during DONE that must be ignored
        write_imem(0, mk(5, 0));
        run_window(12, 6, 9);
        check("t3_store", w_st, 32'h0000_007C);
        check("t3_busy", w_busy, 32'h0000_01FE);
        check("t3_done", w_done, 32'h0000_0200);
        idle(2);

        // No HALT anywhere: implicit end at the last word
        for (int a = 0; a < 16; a++) write_imem(a, mk(1, a * 3 + 1));
        run_program(1'b0, 1'b0, 16'h0, -1, -1);
        check("t4_pc_nowrap", {28'd0, pc}, 32'd15);
        check("t4_base", {19'd0, bus.base_address}, 32'd46);

        // Illegal opcode at pc 2, then a restart clears the flag
        write_imem(0, mk(2, 0)); write_imem(1, mk(1, 13'h033)); write_imem(2, mk(7, 0));
        run_program(1'b1, 1'b0, 16'h0, -1, -1);
        check("t4_error_sticky", {31'd0, error}, 32'd1);
        run_program(1'b1, 1'b0, 16'h0, -1, -1);

        // Reset during COMPUTE, then rerun the retained program
        write_imem(0, mk(1, 13'h055)); write_imem(1, mk(4, 20)); write_imem(2, mk(0, 0));
        run_program(1'b0, 1'b0, 16'h0, -1, 7);
        run_program(1'b0, 1'b0, 16'h0, -1, -1);

        // Writes and starts while busy are dropped; a write with start from IDLE is fetched
        write_imem(0, mk(1, 13'h011)); write_imem(1, mk(4, 10));
        run_program(1'b0, 1'b0, 16'h0, 6, -1);
        run_program(1'b0, 1'b0, 16'h0, -1, -1);
        run_program(1'b0, 1'b1, mk(1, 13'h0CD), -1, -1);

        // Random programs with random op_ready back-pressure
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < 16; a++) begin
                r = $urandom_range(0, 99);
                if (r < 6)       write_imem(a, mk(0, 0));
                else if (r < 9)  write_imem(a, mk($urandom_range(6, 7), 0));
                else if (r < 34) write_imem(a, mk(1, $urandom_range(0, 8191)));
                else if (r < 49) write_imem(a, mk(2, $urandom_range(0, 8191)));
                else if (r < 64) write_imem(a, mk(3, $urandom_range(0, 8191)));
                else if (r < 82) write_imem(a, mk(4, $urandom_range(0, 4)));
                else             write_imem(a, mk(5, $urandom_range(0, 8191)));
            end
            run_program(1'b1, 1'b0, 16'h0, -1, -1);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tpu_sequencer.md
# tpu_sequencer

Parametrised instruction sequencer for the TPU datapath. It holds a writable instruction memory and runs a program on a `start` pulse. Each instruction is decoded into the control strobes that drive the weight/input loaders, the MMU `valid` and the store path. Compared with the previous fixed-program control unit, it adds variable-length COMPUTE, ready/strobe handshakes, a program-load port, busy/done/error status and implicit halt at end of memory.

## Interface

Parameters:
- `OPCODE_W`, default 3: opcode field width, taken from the instruction MSBs.
- `ADDR_W`, default 13: immediate/base-address width; instruction width is `OPCODE_W+ADDR_W`.
- `IMEM_DEPTH`, default 16: number of instruction words (power of 2).
- `PC_W`, default 4: equals log2(IMEM_DEPTH).
- `COMPUTE_CYCLES`, default 6: COMPUTE length used when the immediate is 0.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin a program at pc 0. Ignored while `busy`.
- `imem_we`, in, 1: instruction-memory write enable. Ignored while `busy`.
- `imem_waddr`, in, PC_W: write address.
- `imem_wdata`, in, OPCODE_W+ADDR_W: write data.
- `op_ready`, in, 1: the target of the current LOAD_WEIGHT/LOAD_INPUT/STORE accepts the strobe.
- `base_address`, out, ADDR_W: registered base address.
- `load_weight`, out, 1: load-weight strobe.
- `load_input`, out, 1: load-input strobe.
- `valid`, out, 1: MMU compute-valid.
- `store`, out, 1: store strobe.
- `busy`, out, 1: high in FETCH and EXECUTE.
- `done`, out, 1: one-cycle pulse when a program ends.
- `error`, out, 1: sticky illegal-opcode flag.
- `pc`, out, PC_W: current program counter (debug).

## Operation

Opcodes and their EXECUTE behaviour:
- 000 HALT: end the program.
- 001 LOAD_ADDR: `base_address <= imm` at the end of EXECUTE.
- 010 LOAD_WEIGHT: `load_weight` high.
- 011 LOAD_INPUT: `load_input` high.
- 100 COMPUTE: `valid` high for N cycles; N = `imm` if `imm != 0`, else `COMPUTE_CYCLES`; imm is treated as unsigned.
- 101 STORE: `store` high.
- 110, 111: illegal.

State machine: IDLE, FETCH, EXECUTE, DONE.
- IDLE: on `start`, go to FETCH with `pc <= 0`.
- FETCH: `ir <= imem[pc]`; go to EXECUTE.
- EXECUTE, LOAD_ADDR: one cycle.
- EXECUTE, LOAD_WEIGHT/LOAD_INPUT/STORE: the strobe is held every cycle until `op_ready` is sampled high. The instruction retires in that cycle.
- EXECUTE, COMPUTE: stays in EXECUTE for exactly N cycles; an internal counter counts 0..N-1. It ignores `op_ready`.
- On retire of a non-HALT instruction: if `pc == IMEM_DEPTH-1`, go to DONE (implicit halt, no wrap). Otherwise `pc <= pc+1` and go to FETCH.
- EXECUTE, HALT: go to DONE.
- EXECUTE, illegal opcode: `error <= 1`, no strobes, go to DONE.
- DONE: `done = 1` for one cycle, then IDLE. `pc` holds its last value.

Output rules:
- All strobes are 0 outside EXECUTE; at most one strobe is high in any cycle.
- `base_address` persists across programs.
- `error` is cleared on `reset` or on an accepted `start`.

Instruction memory:
- Not reset; contents survive `reset`.
- Written only when `!busy`.
- An `imem_we` in the same cycle as an accepted `start` is committed before the first FETCH reads it.

## Timing

Reset values:
- state = IDLE; `pc` = 0; `base_address` = 0; `error` = 0.
- All strobes, `busy` and `done` = 0.
- A `reset` mid-program aborts immediately; outputs take the reset values in the next cycle and no `done` pulse is issued.

Cycle timing:
- `start` is sampled in cycle T; FETCH is in T+1; the first EXECUTE is in T+2.
- Non-handshake instructions take 2 cycles (FETCH + EXECUTE).
- COMPUTE takes 1+N cycles.
- Handshake instructions take 1+k cycles, where k is the number of EXECUTE cycles up to and including the one with `op_ready` high.
- A new LOAD_ADDR value is visible on `base_address` in the cycle after its EXECUTE, so it is already valid during the next instruction's strobe.
- `done` is high in the cycle after HALT's EXECUTE; `busy` falls in the same cycle.
- `start` asserted in the DONE cycle is ignored; it is accepted from IDLE, one cycle later.

## Test plan

1. Load program [LOAD_ADDR 0x00F, LOAD_WEIGHT, LOAD_ADDR 0x01E, LOAD_INPUT, COMPUTE imm 0, LOAD_ADDR 0x007, STORE, HALT] with `op_ready` = 1 and start at cycle 0 -> `load_weight` in cycle 4 with `base_address` = 0x00F; `load_input` in cycle 8 with `base_address` = 0x01E; `valid` in cycles 10–15; `store` in cycle 19 with `base_address` = 0x007; `done` in cycle 22.
2. COMPUTE imm = 3, then HALT -> `valid` high for exactly 3 cycles. COMPUTE imm = 1 -> `valid` high for 1 cycle.
3. STORE with `op_ready` held low for 4 cycles, then high -> `store` high for 5 consecutive cycles, and the next FETCH is in the cycle after `op_ready` is high.
4. Memory filled entirely with LOAD_ADDR (no HALT) -> `done` after the retire at pc 15, and `pc` does not wrap. Opcode 111 at pc 2 -> `error` = 1, `done` pulses, no strobes; the next `start` clears `error`.
5. Assert `reset` during COMPUTE -> next cycle `valid` = 0, `busy` = 0, `base_address` = 0, no `done`. Re-`start` reruns the retained program unchanged.
6. `imem_we` and `start` asserted while `busy` -> no effect on memory or `pc`. `start` with an `imem_we` to address 0 in the same cycle (from IDLE) -> the first fetch executes the newly written word.
